// File: rtl/gx_word_align_if.sv
// Receive-side bus of the word aligner: raw ALTGX words in, aligned payload and lock status out.
interface gx_word_align_if;
  logic        pll_locked;
  logic [15:0] rx_data;
  logic [15:0] data_out;
  logic        data_valid;
  logic        sof;
  logic        locked;
  logic [3:0]  offset;
  logic        frame_err;

  modport master (
    output pll_locked, rx_data,
    input  data_out, data_valid, sof, locked, offset, frame_err
  );

  modport slave (
    input  pll_locked, rx_data,
    output data_out, data_valid, sof, locked, offset, frame_err
  );
endinterface

// File: rtl/gx_word_align.sv
// Bit-slip word aligner and frame synchroniser: hunts 16 offsets for the sync word, verifies, then flywheels.
// Latency 2 cycles from the word holding candidate bit k to data_out; one word per clock, no backpressure.
module gx_word_align #(
  parameter logic [15:0] SYNC_WORD  = 16'h5A3C,
  parameter int          FRAME_LEN  = 64,
  parameter int          VERIFY_CNT = 2,
  parameter int          LOSS_CNT   = 3
) (
  input  logic           clk,
  input  logic           rst,
  gx_word_align_if.slave bus
);
  localparam int WW = $clog2(FRAME_LEN);
  localparam int GW = $clog2(VERIFY_CNT + 1);
  localparam int MW = $clog2(LOSS_CNT + 1);
  localparam logic [WW-1:0] LAST = WW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  state_t        state, state_n;
  logic [15:0]   w0, w1;
  logic [30:0]   win;
  logic [15:0]   hits;
  logic [3:0]    first_k;
  logic [15:0]   aligned;
  logic          hit_at;
  logic [WW-1:0] wcnt, wcnt_n;
  logic [GW-1:0] good, good_n;
  logic [MW-1:0] miss, miss_n;
  logic [3:0]    off_q, off_n;
  logic          err_n;
  logic [15:0]   dat_q;
  logic          vld_q, sof_q, lck_q, err_q;

  // Top bit of w0 never falls inside any of the 16 candidate windows.
  assign win = {w0[14:0], w1};

  always_comb begin
    hits    = '0;
    first_k = '0;
    for (int k = 0; k < 16; k++) hits[k] = (win[k +: 16] == SYNC_WORD);
    for (int k = 15; k >= 0; k--) if (hits[k]) first_k = 4'(k);
  end

  assign aligned = win[off_q +: 16];
  assign hit_at  = hits[off_q];

  always_comb begin
    state_n = state;
    wcnt_n  = (state == HUNT) ? wcnt : ((wcnt == LAST) ? '0 : wcnt + 1'b1);
    good_n  = good;
    miss_n  = miss;
    off_n   = off_q;
    err_n   = 1'b0;
    case (state)
      HUNT: begin
        if (|hits) begin
          off_n   = first_k;
          wcnt_n  = WW'(1);
          good_n  = '0;
          state_n = VERIFY;
        end
      end
      VERIFY: begin
        if (wcnt == '0) begin
          if (hit_at) begin
            good_n = good + 1'b1;
            if (good == GW'(VERIFY_CNT - 1)) begin
              state_n = LOCKED;
              miss_n  = '0;
            end
          end else begin
            state_n = HUNT;
            wcnt_n  = '0;
          end
        end
      end
      LOCKED: begin
        if (wcnt == '0) begin
          if (hit_at) begin
            miss_n = '0;
          end else begin
            err_n  = 1'b1;
            miss_n = miss + 1'b1;
            if (miss == MW'(LOSS_CNT - 1)) begin
              state_n = HUNT;
              wcnt_n  = '0;
            end
          end
        end
      end
      default: state_n = HUNT;
    endcase
    // Transceiver lost lock: the deserialised stream is meaningless, start over.
    if (!bus.pll_locked) begin
      state_n = HUNT;
      wcnt_n  = '0;
      good_n  = '0;
      miss_n  = '0;
      off_n   = '0;
      err_n   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w0    <= '0;
      w1    <= '0;
      state <= HUNT;
      wcnt  <= '0;
      good  <= '0;
      miss  <= '0;
      off_q <= '0;
      dat_q <= '0;
      vld_q <= 1'b0;
      sof_q <= 1'b0;
      lck_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      w0    <= bus.rx_data;
      w1    <= w0;
      state <= state_n;
      wcnt  <= wcnt_n;
      good  <= good_n;
      miss  <= miss_n;
      off_q <= off_n;
      dat_q <= bus.pll_locked ? aligned : '0;
      vld_q <= bus.pll_locked && (state == LOCKED) && (wcnt != '0);
      sof_q <= bus.pll_locked && (state == LOCKED) && (wcnt == WW'(1));
      lck_q <= (state_n == LOCKED);
      err_q <= err_n;
    end
  end

  assign bus.data_out   = dat_q;
  assign bus.data_valid = vld_q;
  assign bus.sof        = sof_q;
  assign bus.locked     = lck_q;
  assign bus.offset     = off_q;
  assign bus.frame_err  = err_q;
endmodule

// File: tb/tb_gx_word_align.sv
// Directed bench for gx_word_align: frame streams with chosen bit slip, sync corruption and PLL drops.
module tb_gx_word_align;
  localparam logic [15:0] SYNC = 16'h5A3C;

  typedef struct packed {
    logic [15:0] dat;
    logic        vld;
    logic        sof;
    logic        lck;
    logic        err;
    logic [3:0]  off;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] txq[$];
  obs_t        obs[$];

  always #5 clk = ~clk;

  gx_word_align_if bus ();

  gx_word_align #(
    .SYNC_WORD (16'h5A3C),
    .FRAME_LEN (64),
    .VERIFY_CNT(2),
    .LOSS_CNT  (3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic logic [15:0] pld(int idx);
    return {8'h00, idx[7:0]};
  endfunction

  // pre payload words, then nfr frames of 64 words; bad[f] replaces the sync of frame f by zero.
  task automatic build(input int pre, input int nfr, input logic [31:0] bad);
    txq.delete();
    for (int i = 0; i < pre; i++) txq.push_back(pld(i));
    for (int f = 0; f < nfr; f++)
      for (int j = 0; j < 64; j++)
        txq.push_back((j == 0) ? (bad[f] ? 16'h0000 : SYNC) : pld(pre + f * 64 + j));
    txq.push_back(16'h0000);
    txq.push_back(16'h0000);
  endtask

  // obs[j] holds the outputs produced for transmitted word j (two clocks after it enters).
  task automatic run(input int slip, input int lo_start, input int lo_len);
    logic [15:0] prev;
    logic [31:0] cat;
    prev = 16'h0000;
    obs.delete();
    for (int i = 0; i < txq.size(); i++) begin
      cat = {txq[i], prev};
      bus.rx_data    = 16'(cat >> (16 - slip));
      bus.pll_locked = !(i >= lo_start && i < lo_start + lo_len);
      prev = txq[i];
      @(posedge clk);
      #1;
      if (i >= 2)
        obs.push_back('{dat: bus.data_out, vld: bus.data_valid, sof: bus.sof,
                        lck: bus.locked, err: bus.frame_err, off: bus.offset});
    end
    bus.pll_locked = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.rx_data = 16'h0000;
    bus.pll_locked = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.data_out !== 16'h0000) begin errors++; $display("FAIL rst_data_out: got %h exp 0000", bus.data_out); end
    checks++; if (bus.data_valid !== 1'b0) begin errors++; $display("FAIL rst_data_valid: got %b exp 0", bus.data_valid); end
    checks++; if (bus.sof !== 1'b0) begin errors++; $display("FAIL rst_sof: got %b exp 0", bus.sof); end
    checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL rst_locked: got %b exp 0", bus.locked); end
    checks++; if (bus.offset !== 4'd0) begin errors++; $display("FAIL rst_offset: got %0d exp 0", bus.offset); end
    checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL rst_frame_err: got %b exp 0", bus.frame_err); end
  endtask

  task automatic test_offset0();
    int nv, ns;
    do_reset();
    build(0, 4, 32'h0);
    run(0, -1, 0);
    nv = 0;
    for (int j = 0; j < 128; j++) nv += int'(obs[j].vld);
    checks++; if (nv !== 0) begin errors++; $display("FAIL o0_valid_before_lock: got %0d exp 0", nv); end
    checks++; if (obs[127].lck !== 1'b0) begin errors++; $display("FAIL o0_lock_early: got %b exp 0", obs[127].lck); end
    checks++; if (obs[128].lck !== 1'b1) begin errors++; $display("FAIL o0_lock_rise: got %b exp 1", obs[128].lck); end
    checks++; if (obs[128].vld !== 1'b0) begin errors++; $display("FAIL o0_sync_slot_valid: got %b exp 0", obs[128].vld); end
    checks++; if (obs[129].sof !== 1'b1 || obs[129].vld !== 1'b1) begin errors++; $display("FAIL o0_first_sof: got sof=%b vld=%b exp 1 1", obs[129].sof, obs[129].vld); end
    checks++; if (obs[129].dat !== 16'h0081) begin errors++; $display("FAIL o0_first_data: got %h exp 0081", obs[129].dat); end
    checks++; if (obs[129].off !== 4'd0) begin errors++; $display("FAIL o0_offset: got %0d exp 0", obs[129].off); end
    checks++; if (obs[191].dat !== 16'h00BF) begin errors++; $display("FAIL o0_last_data: got %h exp 00bf", obs[191].dat); end
    nv = 0; ns = 0;
    for (int j = 128; j < 192; j++) nv += int'(obs[j].vld);
    for (int j = 128; j < 256; j++) ns += int'(obs[j].sof);
    checks++; if (nv !== 63) begin errors++; $display("FAIL o0_valid_per_frame: got %0d exp 63", nv); end
    checks++; if (ns !== 2) begin errors++; $display("FAIL o0_sof_count: got %0d exp 2", ns); end
    checks++; if (obs[192].vld !== 1'b0 || obs[192].err !== 1'b0) begin errors++; $display("FAIL o0_good_sync_slot: got vld=%b err=%b exp 0 0", obs[192].vld, obs[192].err); end
  endtask

  task automatic test_offset7();
    int bad;
    do_reset();
    build(0, 4, 32'h0);
    run(7, -1, 0);
    checks++; if (obs[127].lck !== 1'b0 || obs[128].lck !== 1'b1) begin errors++; $display("FAIL o7_lock_edge: got %b%b exp 01", obs[127].lck, obs[128].lck); end
    checks++; if (obs[129].off !== 4'd7) begin errors++; $display("FAIL o7_offset: got %0d exp 7", obs[129].off); end
    checks++; if (obs[129].dat !== 16'h0081 || obs[129].sof !== 1'b1) begin errors++; $display("FAIL o7_first_word: got %h sof=%b exp 0081 sof=1", obs[129].dat, obs[129].sof); end
    bad = 0;
    for (int j = 129; j < 192; j++) if (obs[j].vld !== 1'b1 || obs[j].dat !== pld(j)) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL o7_payload: got %0d bad words exp 0", bad); end
    checks++; if (obs[200].dat !== 16'h00C8) begin errors++; $display("FAIL o7_frame3_data: got %h exp 00c8", obs[200].dat); end
  endtask

  task automatic test_single_miss();
    int ne;
    do_reset();
    build(0, 7, 32'h0000_0068); // frames 3, 5, 6 lose their sync
    run(0, -1, 0);
    checks++; if (obs[192].err !== 1'b1 || obs[192].lck !== 1'b1) begin errors++; $display("FAIL sm_first_miss: got err=%b lck=%b exp 1 1", obs[192].err, obs[192].lck); end
    checks++; if (obs[192].vld !== 1'b0) begin errors++; $display("FAIL sm_missed_slot_valid: got %b exp 0", obs[192].vld); end
    checks++; if (obs[191].err !== 1'b0 || obs[193].err !== 1'b0) begin errors++; $display("FAIL sm_pulse_width: got %b%b exp 00", obs[191].err, obs[193].err); end
    checks++; if (obs[193].vld !== 1'b1 || obs[193].sof !== 1'b1 || obs[193].dat !== 16'h00C1) begin errors++; $display("FAIL sm_payload_after_miss: got vld=%b sof=%b %h exp 1 1 00c1", obs[193].vld, obs[193].sof, obs[193].dat); end
    checks++; if (obs[256].err !== 1'b0) begin errors++; $display("FAIL sm_good_sync: got %b exp 0", obs[256].err); end
    checks++; if (obs[384].lck !== 1'b1 || obs[384].err !== 1'b1) begin errors++; $display("FAIL sm_miss_cleared: got lck=%b err=%b exp 1 1", obs[384].lck, obs[384].err); end
    checks++; if (obs[385].vld !== 1'b1) begin errors++; $display("FAIL sm_still_flowing: got %b exp 1", obs[385].vld); end
    ne = 0;
    for (int j = 0; j < obs.size(); j++) ne += int'(obs[j].err);
    checks++; if (ne !== 3) begin errors++; $display("FAIL sm_err_count: got %0d exp 3", ne); end
  endtask

  task automatic test_loss_relock();
    int ne, nv;
    do_reset();
    build(0, 9, 32'h0000_0038); // frames 3, 4, 5 lose their sync
    run(0, -1, 0);
    ne = 0;
    for (int j = 0; j < obs.size(); j++) ne += int'(obs[j].err);
    checks++; if (ne !== 3) begin errors++; $display("FAIL ll_err_count: got %0d exp 3", ne); end
    checks++; if (obs[319].lck !== 1'b1 || obs[319].vld !== 1'b1) begin errors++; $display("FAIL ll_before_loss: got lck=%b vld=%b exp 1 1", obs[319].lck, obs[319].vld); end
    checks++; if (obs[320].lck !== 1'b0 || obs[320].err !== 1'b1) begin errors++; $display("FAIL ll_loss_edge: got lck=%b err=%b exp 0 1", obs[320].lck, obs[320].err); end
    nv = 0;
    for (int j = 320; j < 512; j++) nv += int'(obs[j].vld);
    checks++; if (nv !== 0) begin errors++; $display("FAIL ll_valid_after_loss: got %0d exp 0", nv); end
    checks++; if (obs[511].lck !== 1'b0 || obs[512].lck !== 1'b1) begin errors++; $display("FAIL ll_relock_edge: got %b%b exp 01", obs[511].lck, obs[512].lck); end
    checks++; if (obs[513].sof !== 1'b1 || obs[513].dat !== 16'h0001) begin errors++; $display("FAIL ll_relock_sof: got sof=%b %h exp 1 0001", obs[513].sof, obs[513].dat); end
  endtask

  task automatic test_false_sync();
    int nl;
    do_reset();
    build(40, 4, 32'h0);
    txq[10] = SYNC;
    run(0, -1, 0);
    nl = 0;
    for (int j = 0; j < 232; j++) nl += int'(obs[j].lck);
    checks++; if (nl !== 0) begin errors++; $display("FAIL fs_early_lock: got %0d locked cycles exp 0", nl); end
    checks++; if (obs[232].lck !== 1'b1) begin errors++; $display("FAIL fs_real_lock: got %b exp 1", obs[232].lck); end
    checks++; if (obs[233].sof !== 1'b1 || obs[233].dat !== 16'h00E9) begin errors++; $display("FAIL fs_first_word: got sof=%b %h exp 1 00e9", obs[233].sof, obs[233].dat); end
  endtask

  task automatic test_pll_drop();
    do_reset();
    build(0, 6, 32'h0);
    run(7, 150, 10);
    checks++; if (obs[147].lck !== 1'b1 || obs[147].vld !== 1'b1) begin errors++; $display("FAIL pd_before_drop: got lck=%b vld=%b exp 1 1", obs[147].lck, obs[147].vld); end
    checks++; if (obs[148] !== '0) begin errors++; $display("FAIL pd_first_low: got %h exp 0", obs[148]); end
    checks++; if (obs[157] !== '0) begin errors++; $display("FAIL pd_last_low: got %h exp 0", obs[157]); end
    checks++; if (obs[319].lck !== 1'b0 || obs[320].lck !== 1'b1) begin errors++; $display("FAIL pd_relock_edge: got %b%b exp 01", obs[319].lck, obs[320].lck); end
    checks++; if (obs[321].off !== 4'd7 || obs[321].sof !== 1'b1 || obs[321].dat !== 16'h0041) begin errors++; $display("FAIL pd_relock_word: got off=%0d sof=%b %h exp 7 1 0041", obs[321].off, obs[321].sof, obs[321].dat); end
  endtask

  task automatic test_async_reset();
    checks++; if (bus.locked !== 1'b1 || bus.data_valid !== 1'b1) begin errors++; $display("FAIL ar_pre_state: got lck=%b vld=%b exp 1 1", bus.locked, bus.data_valid); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL ar_locked: got %b exp 0", bus.locked); end
    checks++; if (bus.data_valid !== 1'b0) begin errors++; $display("FAIL ar_data_valid: got %b exp 0", bus.data_valid); end
    checks++; if (bus.offset !== 4'd0) begin errors++; $display("FAIL ar_offset: got %0d exp 0", bus.offset); end
    checks++; if (bus.data_out !== 16'h0000 || bus.sof !== 1'b0 || bus.frame_err !== 1'b0) begin errors++; $display("FAIL ar_others: got %h sof=%b err=%b exp 0000 0 0", bus.data_out, bus.sof, bus.frame_err); end
    do_reset();
  endtask

  initial begin
    bus.rx_data = 16'h0000;
    bus.pll_locked = 1'b1;
    test_reset();
    test_offset0();
    test_offset7();
    test_single_miss();
    test_loss_relock();
    test_false_sync();
    test_pll_drop();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
